// File: rtl/dadder_bcd_core.sv
`default_nettype none
// ============================================================================
//  Module      : dadder_bcd_core
//  Description : Digit-serial BCD adder/subtracter, one digit per clock, with
//                a second ten's-complement pass for negative differences.
//  Revision    : 1.0 - initial release
// ============================================================================
module dadder_bcd_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_in,
    output logic                  rdy_out,
    input  logic                  op_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  vld_out,
    output logic                  of_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_out
);

    localparam int                 C_NDIG  = DATA_WIDTH / 4;
    localparam int                 C_CNT_W = (C_NDIG > 1) ? $clog2(C_NDIG) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [C_CNT_W-1:0]    r_cnt;
    logic                  r_carry;
    logic                  r_op;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_of;
    logic                  r_err_out;

    logic [C_NDIG-1:0]     w_bad_nib;
    logic                  w_in_err;
    logic [3:0]            w_opa;
    logic [3:0]            w_opb;
    logic [4:0]            w_sum;
    logic                  w_carry;
    logic [3:0]            w_digit;
    logic [DATA_WIDTH-1:0] w_res_next;
    logic                  w_last;

    for (genvar gi = 0; gi < C_NDIG; gi++) begin : g_nib_chk
        assign w_bad_nib[gi] = (a_in[4*gi +: 4] > 4'd9) || (b_in[4*gi +: 4] > 4'd9);
    end
    assign w_in_err = |w_bad_nib;

    // NEG reuses the digit adder: 9's complement of the stored result plus carry.
    assign w_opa      = (r_state == S_NEG) ? (4'd9 - r_res[3:0]) : r_a[3:0];
    assign w_opb      = (r_state == S_NEG) ? 4'd0 :
                        (r_op ? (4'd9 - r_b[3:0]) : r_b[3:0]);
    assign w_sum      = {1'b0, w_opa} + {1'b0, w_opb} + {4'b0000, r_carry};
    assign w_carry    = (w_sum > 5'd9);
    assign w_digit    = w_carry ? (w_sum[3:0] - 4'd10) : w_sum[3:0];
    assign w_res_next = (r_res >> 4) | (DATA_WIDTH'(w_digit) << (DATA_WIDTH - 4));
    assign w_last     = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (vld_in) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = (r_op && !w_carry) ? S_NEG : S_DONE;
                end
            end
            S_NEG: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_op      <= 1'b0;
            r_err     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_data    <= '0;
            r_of      <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vld_in) begin
                        r_op    <= op_in;
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_cnt   <= '0;
                        r_carry <= op_in;
                        r_err   <= w_in_err;
                    end
                end
                S_CALC, S_NEG: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_cnt   <= w_last ? '0 : (r_cnt + C_CNT_W'(1));
                    // Carry of 1 seeds the +1 of the ten's-complement pass.
                    r_carry <= w_last ? 1'b1 : w_carry;
                    if (w_state_next == S_DONE) begin
                        r_data    <= w_res_next;
                        r_of      <= (r_state == S_NEG) || (!r_op && w_carry);
                        r_err_out <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdy_out  = (r_state == S_IDLE);
    assign vld_out  = (r_state == S_DONE);
    assign of_out   = r_of;
    assign data_out = r_data;
    assign err_out  = r_err_out;

endmodule
`default_nettype wire

// File: tb/tb_dadder_bcd_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dadder_bcd_core
//  Description : Scoreboard bench for dadder_bcd_core with DATA_WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dadder_bcd_core;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          vld_in;
    logic          rdy_out;
    logic          op_in;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          vld_out;
    logic          of_out;
    logic [DW-1:0] data_out;
    logic          err_out;

    dadder_bcd_core #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (vld_in),
        .rdy_out  (rdy_out),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .vld_out  (vld_out),
        .of_out   (of_out),
        .data_out (data_out),
        .err_out  (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          of;
        logic          err;
        logic          chk_d;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   acc_hist[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: records accept edges and compares each vld_out pulse to the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        if (reset) begin
            acc_q.delete();
        end else if (vld_in && rdy_out) begin
            acc_q.push_back(cyc + 1);
            acc_hist.push_back(cyc + 1);
        end
        if (vld_out) begin
            if (sb_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld: vld_out=1 with no pending operation (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                k = acc_q.pop_front();
                if (e.chk_d) begin
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("of_out", 32'(of_out), 32'(e.of));
                end
                chk("err_out", 32'(err_out), 32'(e.err));
                chk("latency", cyc - k + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic expect_res, input logic [DW-1:0] ed, input logic eof,
                         input logic eerr, input logic chkd, input int lat, output int busy);
        exp_t e;
        logic got;
        op_in  = op;
        a_in   = a;
        b_in   = b;
        vld_in = 1'b1;
        busy   = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rdy_out) got = 1'b1;
            else busy++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: rdy_out stayed 0 for 40 cycles");
        end
        if (expect_res) begin
            e.d = ed; e.of = eof; e.err = eerr; e.chk_d = chkd; e.lat = lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] ed, input logic eof, input logic eerr,
                          input logic chkd, input int lat);
        int busy;
        issue(op, a, b, 1'b1, ed, eof, eerr, chkd, lat, busy);
        vld_in = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int busy;
        reset  = 1'b1;
        vld_in = 1'b0;
        op_in  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(rdy_out), 32'd1);
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_of", 32'(of_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b1, 5);
        run_op(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 5);
        run_op(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5);
        run_op(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b1, 5);
        run_op(1'b1, 16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 1'b1, 9);

        // vld_in stays high across two back-to-back requests
        issue(1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 5, busy);
        issue(1'b0, 16'h0009, 16'h0009, 1'b1, 16'h0018, 1'b0, 1'b0, 1'b1, 5, busy);
        vld_in = 1'b0;
        chk("b2b_busy_cycles", busy, 5);
        chk("b2b_accept_spacing", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], 6);

        // Abort during CALC digit 2; no result is expected for it
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0, busy);
        vld_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rdy", 32'(rdy_out), 32'd1);
        chk("abort_vld", 32'(vld_out), 32'd0);
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_of", 32'(of_out), 32'd0);
        chk("abort_err", 32'(err_out), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        run_op(1'b0, 16'h0042, 16'h0058, 16'h0100, 1'b0, 1'b0, 1'b1, 5);
        run_op(1'b0, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 5);
        run_op(1'b0, 16'h0005, 16'h0004, 16'h0009, 1'b0, 1'b0, 1'b1, 5);

        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(posedge clk);
        chk("pending_results", sb_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dadder_bcd_core.md
# dadder_bcd_core

Digit-serial decimal (BCD) adder/subtracter. It is the datapath core of the decimal adder block and produces the data plane output stream of `vld_out`, `of_out` and `data_out`. It accepts one operation at a time through a valid/ready handshake and processes one BCD digit per clock. A subtraction with a negative result gets a second ten's-complement pass, and the magnitude and sign are then presented as a one-cycle output pulse.

## Interface
- `DATA_WIDTH`, default 32: operand/result width in bits. Must be a multiple of 4 and ≥ 4. Digit count N = DATA_WIDTH/4.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `vld_in`  in  1: operation request.
- `rdy_out`  out  1: core is idle and can accept a request. Decoded from state IDLE.
- `op_in`  in  1: 0 = add (a+b), 1 = subtract (a−b).
- `a_in`  in  DATA_WIDTH: operand A, packed BCD, digit 0 in bits [3:0].
- `b_in`  in  DATA_WIDTH: operand B, packed BCD.
- `vld_out`  out  1: one-cycle pulse; result lines are valid.
- `of_out`  out  1: carry-out of the MSD for add; negative sign for subtract.
- `data_out`  out  DATA_WIDTH: result. For subtract this is the magnitude |a−b|.
- `err_out`  out  1: asserted with `vld_out` if any nibble of `a_in`/`b_in` was > 9 at acceptance.

## Operation
- Accept: `vld_in && rdy_out` at a rising edge. `op_in`, `a_in` and `b_in` are registered on that edge. Inputs are ignored when not accepted, and there is no queueing.
- States:
  - IDLE:
    - `rdy_out`=1.
    - Go to CALC on accept.
    - Clear the digit counter.
    - Set carry-in = `op_in`.
    - Set the err flag from the nibble check.
  - CALC: one digit per cycle, digit index 0..N−1.
    - sum = a_d + b'_d + c, where b'_d = b_d for add and 9−b_d for subtract.
    - If sum > 9: digit = sum − 10, carry = 1. Otherwise digit = sum, carry = 0.
    - After digit N−1:
      - Add: go to DONE with of = final carry.
      - Subtract with final carry 1: go to DONE with of = 0.
      - Subtract with final carry 0: go to NEG.
  - NEG: N cycles; digit-serial 9's complement of the CALC result plus 1 (carry-in 1). Set of = 1 and go to DONE.
  - DONE: one cycle.
    - `vld_out`=1.
    - Drive `data_out`/`of_out`/`err_out`.
    - Go to IDLE.
- The result is kept modulo 10^N; there is no widening. Add overflow is reported only through `of_out`.
- With non-BCD input digits, `data_out` is unspecified, but latency and the state sequence are unchanged and `err_out`=1.
- `data_out`, `of_out` and `err_out` hold their last values until the next DONE. Only `vld_out` is a pulse.
- There is no output back-pressure; downstream must sample on `vld_out`.

## Timing
- Reset values:
  - state = IDLE, so `rdy_out`=1 during and after reset.
  - `vld_out`=0, `of_out`=0, `data_out`=0, `err_out`=0.
  - Internal counter and carry are cleared.
- Latency, with the accept edge at edge k:
  - Add, and subtract with a result ≥ 0: `vld_out` high in the cycle after edge k+N. This is N+1 cycles.
  - Negative subtract: `vld_out` high after edge k+2N. This is 2N+1 cycles.
  - `rdy_out` is 0 from edge k until the edge that leaves DONE, and returns to 1 in the cycle after the `vld_out` pulse.
- Back-to-back operation: a request held high during a busy period is accepted on the first edge with `rdy_out`=1. Minimum spacing between accepts is N+2 cycles.
- Reset mid-operation (CALC, NEG or DONE): the core is in IDLE the next cycle. No `vld_out` pulse is produced for the aborted operation and outputs go to their reset values.
- Reset wins over a simultaneous accept; the request is not captured.

## Test plan
All scenarios use DATA_WIDTH=16 (N=4).
- Add 0x1234 + 0x4321 → `data_out`=0x5555, `of_out`=0, `err_out`=0; `vld_out` 5 cycles after accept.
- Add 0x9999 + 0x0001 → `data_out`=0x0000, `of_out`=1. Then 0x0000 − 0x0000 → 0x0000, `of_out`=0, latency 5.
- Subtract 0x5000 − 0x1234 → `data_out`=0x3766, `of_out`=0, latency 5. Subtract 0x0100 − 0x0250 → `data_out`=0x0150, `of_out`=1, latency 9.
- `vld_in` held high across two operations (0x0001+0x0002, then 0x0009+0x0009) → results 0x0003 and 0x0018. The second accept is 6 cycles after the first, and `rdy_out` is 0 while busy.
- Assert `reset` for 1 cycle at CALC digit 2 → no `vld_out`; the next cycle has `rdy_out`=1 and all outputs 0. A fresh 0x0042+0x0058 then gives 0x0100.
- `a_in`=0x00A0 + 0x0001 → `err_out`=1 with `vld_out`, latency 5. The next valid operation gives `err_out`=0.
